i2s_audio_in: RTL and testbench

- I2S capture block for the WM8731 codec ADC path on DE2-115: AUD_ADCDAT in, with AUD_BCLK and AUD_ADCLRCK as inputs.
- It is the receive counterpart of i2s_audio_out. The codec clocks are generated elsewhere; this block only observes them.
- It oversamples bclk/lrclk/sdata in the clk domain, deserializes MSB-first I2S words and presents a left/right stereo pair with a one-cycle valid strobe to lab logic.

---
 rtl/i2s_pkg.sv | 18 +
 rtl/i2s_audio_in_if.sv | 23 ++
 rtl/i2s_in_sync.sv | 37 +++
 rtl/i2s_audio_in.sv | 129 ++++++++++++
 tb/tb_i2s_audio_in.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/i2s_pkg.sv
// Shared types and helpers for the I2S ADC capture path.
package i2s_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        WAIT
    } i2s_rx_state_t;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

    // Bits needed for a counter that must reach w itself, not just w-1.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/i2s_audio_in_if.sv
// Codec-facing serial lines plus the stereo sample output bundle of i2s_audio_in.
interface i2s_audio_in_if #(
    parameter int w_sample = 16
);
    logic                bclk;
    logic                lrclk;
    logic                sdata;
    logic                err_clr;
    logic [w_sample-1:0] left;
    logic [w_sample-1:0] right;
    logic                valid;
    logic                frame_error;

    modport master (
        output bclk, lrclk, sdata, err_clr,
        input  left, right, valid, frame_error
    );

    modport slave (
        input  bclk, lrclk, sdata, err_clr,
        output left, right, valid, frame_error
    );
endinterface

// File: rtl/i2s_in_sync.sv
// Two-flop synchronizers for the codec lines plus a bclk rising-edge strobe.
module i2s_in_sync (
    input  logic clk,
    input  logic rst,
    input  logic bclk,
    input  logic lrclk,
    input  logic sdata,
    output logic be,
    output logic lrclk_s,
    output logic sdata_s
);
    logic [1:0] bclk_ff;
    logic [1:0] lrclk_ff;
    logic [1:0] sdata_ff;
    logic       bclk_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bclk_ff   <= '0;
            lrclk_ff  <= '0;
            sdata_ff  <= '0;
            bclk_prev <= 1'b0;
        end else begin
            // NOTE: non-blocking so each stage takes its predecessor's value from before this edge.
            bclk_ff   <= {bclk_ff[0], bclk};
            lrclk_ff  <= {lrclk_ff[0], lrclk};
            sdata_ff  <= {sdata_ff[0], sdata};
            bclk_prev <= bclk_ff[1];
        end
    end

    // All three lines share the same depth, so data and word clock stay aligned to be.
    assign be      = bclk_ff[1] & ~bclk_prev;
    assign lrclk_s = lrclk_ff[1];
    assign sdata_s = sdata_ff[1];

endmodule

// File: rtl/i2s_audio_in.sv
// I2S receiver for the WM8731 ADC path: deserializes MSB-first words into a left/right pair.
module i2s_audio_in
    import i2s_pkg::*;
#(
    parameter int clk_mhz  = 50,
    parameter int w_sample = 16
) (
    input logic           clk,
    input logic           rst,
    i2s_audio_in_if.slave bus
);
    localparam int CW = cnt_width(w_sample);

    if (w_sample < 8 || w_sample > 32 || clk_mhz < 4) begin : g_bad_param
        $error("i2s_audio_in: w_sample must be 8..32 and clk_mhz at least 4");
    end

    logic be, lrclk_s, sdata_s, le;

    i2s_in_sync u_sync (
        .clk    (clk),
        .rst    (rst),
        .bclk   (bus.bclk),
        .lrclk  (bus.lrclk),
        .sdata  (bus.sdata),
        .be     (be),
        .lrclk_s(lrclk_s),
        .sdata_s(sdata_s)
    );

    i2s_rx_state_t       state, state_nx;
    logic [CW-1:0]       cnt, cnt_nx;
    logic [w_sample-2:0] sr, sr_nx;
    logic [w_sample-1:0] left_hold, left_hold_nx, word;
    logic                ch, ch_nx, left_ok, left_ok_nx, lr_prev;
    logic                done, pair, err_set;

    assign le   = be && (lrclk_s != lr_prev);
    assign word = {sr, sdata_s};

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_nx     = state;
        cnt_nx       = cnt;
        sr_nx        = sr;
        ch_nx        = ch;
        left_hold_nx = left_hold;
        left_ok_nx   = left_ok;
        done         = 1'b0;
        pair         = 1'b0;
        err_set      = 1'b0;

        case (state)
            IDLE, WAIT: begin
                if (le) begin
                    state_nx = SHIFT;
                    cnt_nx   = '0;
                    ch_nx    = lrclk_s;
                end
            end
            SHIFT: begin
                if (le) begin
                    // The bit on an lrclk edge is the LSB of the slot that is ending.
                    if (cnt == CW'(w_sample - 1)) begin
                        done = 1'b1;
                    end else begin
                        err_set    = 1'b1;
                        left_ok_nx = 1'b0;
                    end
                    cnt_nx = '0;
                    ch_nx  = lrclk_s;
                end else if (be) begin
                    sr_nx  = word[w_sample-2:0];
                    cnt_nx = cnt + CW'(1);
                    if (cnt == CW'(w_sample - 1)) begin
                        done     = 1'b1;
                        state_nx = WAIT;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

        if (done) begin
            if (ch == CH_LEFT) begin
                left_hold_nx = word;
                left_ok_nx   = 1'b1;
            end else if (ch == CH_RIGHT && left_ok) begin
                pair       = 1'b1;
                left_ok_nx = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            sr              <= '0;
            ch              <= CH_LEFT;
            lr_prev         <= 1'b0;
            left_hold       <= '0;
            left_ok         <= 1'b0;
            bus.left        <= '0;
            bus.right       <= '0;
            bus.valid       <= 1'b0;
            bus.frame_error <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            sr        <= sr_nx;
            ch        <= ch_nx;
            left_hold <= left_hold_nx;
            left_ok   <= left_ok_nx;
            if (be) lr_prev <= lrclk_s;
            bus.valid <= pair;
            if (pair) begin
                bus.left  <= left_hold;
                bus.right <= word;
            end
            // A new short slot outranks a clear arriving in the same cycle.
            if (err_set)
                bus.frame_error <= 1'b1;
            else if (bus.err_clr)
                bus.frame_error <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i2s_audio_in.sv
// Directed bench for i2s_audio_in: serial I2S frames in, scoreboarded stereo pairs out.
`timescale 1ns / 100ps
module tb_i2s_audio_in;

    localparam int HALF = 8;  // bclk half period in clk cycles: 3.125 MHz at 50 MHz clk

    typedef struct {
        logic [31:0] l;
        logic [31:0] r;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    logic bclk_l[2], lrclk_l[2], sdata_l[2], err_clr_l[2];
    logic pend_bit[2];
    bit   pend_lsb[2], pend_push[2];
    logic [31:0] pend_l[2], pend_r[2];
    bit   clr_on_le = 1'b0;
    int   last_rise[2] = '{-1, -1};

    exp_t q16[$];
    exp_t q32[$];

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    i2s_audio_in_if #(.w_sample(16)) if16 ();
    i2s_audio_in_if #(.w_sample(32)) if32 ();

    assign if16.bclk    = bclk_l[0];
    assign if16.lrclk   = lrclk_l[0];
    assign if16.sdata   = sdata_l[0];
    assign if16.err_clr = err_clr_l[0];
    assign if32.bclk    = bclk_l[1];
    assign if32.lrclk   = lrclk_l[1];
    assign if32.sdata   = sdata_l[1];
    assign if32.err_clr = err_clr_l[1];

    i2s_audio_in #(.clk_mhz(50), .w_sample(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));
    i2s_audio_in #(.clk_mhz(50), .w_sample(32)) dut32 (.clk(clk), .rst(rst), .bus(if32));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // bclk must stay at or below clk/4: at least 4 clk cycles between rises.
    always @(posedge bclk_l[0]) begin
        if (last_rise[0] >= 0) check("bclk_rate16", 64'(cyc - last_rise[0] >= 4), 64'd1);
        last_rise[0] = cyc;
    end
    always @(posedge bclk_l[1]) begin
        if (last_rise[1] >= 0) check("bclk_rate32", 64'(cyc - last_rise[1] >= 4), 64'd1);
        last_rise[1] = cyc;
    end

    // Scoreboard consumers: each valid must match the oldest expected pair and its latency.
    always @(negedge clk) begin
        exp_t e;
        if (if16.valid === 1'b1) begin
            if (q16.size() == 0) begin
                check("unexpected_valid16", 64'd1, 64'd0);
            end else begin
                e = q16.pop_front();
                check("left16", 64'(if16.left), 64'(e.l));
                check("right16", 64'(if16.right), 64'(e.r));
                check("latency16", 64'(cyc), 64'(e.cyc + 3));
            end
        end
        if (if32.valid === 1'b1) begin
            if (q32.size() == 0) begin
                check("unexpected_valid32", 64'd1, 64'd0);
            end else begin
                e = q32.pop_front();
                check("left32", 64'(if32.left), 64'(e.l));
                check("right32", 64'(if32.right), 64'(e.r));
                check("latency32", 64'(cyc), 64'(e.cyc + 3));
            end
        end
    end

    task automatic line_reset(input int sel);
        pend_bit[sel]  = 1'b0;
        pend_lsb[sel]  = 1'b0;
        pend_push[sel] = 1'b0;
    endtask

    // One I2S slot: lrclk changes with the previous slot's LSB, MSB follows one bclk later.
    task automatic send_slot(input int sel, input logic lr, input logic [31:0] w_data, input int w,
                             input int slot, input bit push, input logic [31:0] pl,
                             input logic [31:0] pr);
        exp_t e;
        for (int i = 0; i < slot; i++) begin
            lrclk_l[sel] = lr;
            sdata_l[sel] = pend_bit[sel];
            repeat (HALF) @(negedge clk);
            bclk_l[sel] = 1'b1;
            if (pend_lsb[sel] && pend_push[sel]) begin
                e.l   = pend_l[sel];
                e.r   = pend_r[sel];
                e.cyc = cyc;
                if (sel == 0) q16.push_back(e);
                else q32.push_back(e);
            end
            if (i == 0 && clr_on_le) begin
                repeat (2) @(negedge clk);
                err_clr_l[sel] = 1'b1;
                @(negedge clk);
                err_clr_l[sel] = 1'b0;
                repeat (HALF - 3) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            bclk_l[sel]   = 1'b0;
            pend_bit[sel] = (i < w) ? w_data[w-1-i] : 1'($urandom);
            pend_lsb[sel] = (lr == 1'b1) && (i == w - 1);
            pend_push[sel] = push;
            pend_l[sel]   = pl;
            pend_r[sel]   = pr;
        end
    endtask

    task automatic send_frame(input int sel, input logic [31:0] l, input logic [31:0] r,
                              input int w, input int slot, input bit push);
        send_slot(sel, 1'b0, l, w, slot, 1'b0, l, r);
        send_slot(sel, 1'b1, r, w, slot, push, l, r);
    endtask

    task automatic pulse_clear();
        err_clr_l[0] = 1'b1;
        @(negedge clk);
        err_clr_l[0] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            bclk_l[s] = 1'b0; lrclk_l[s] = 1'b0; sdata_l[s] = 1'b0; err_clr_l[s] = 1'b0;
            line_reset(s);
        end
        repeat (3) @(negedge clk);
        check("rst_left16", 64'(if16.left), 64'd0);
        check("rst_right16", 64'(if16.right), 64'd0);
        check("rst_valid16", 64'(if16.valid), 64'd0);
        check("rst_ferr16", 64'(if16.frame_error), 64'd0);
        check("rst_left32", 64'(if32.left), 64'd0);
        check("rst_valid32", 64'(if32.valid), 64'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Nominal: the first frame only produces the lrclk edge that wakes the receiver.
        send_frame(0, 32'h5555, 32'h6666, 16, 32, 1'b0);
        send_frame(0, 32'h8001, 32'h7FFE, 16, 32, 1'b1);
        send_frame(0, 32'h8001, 32'h7FFE, 16, 32, 1'b1);
        check("nominal_drained", 64'(q16.size()), 64'd0);
        repeat (20) @(negedge clk);
        check("hold_left16", 64'(if16.left), 64'h8001);
        check("hold_right16", 64'(if16.right), 64'h7FFE);

        // Oversize slot: trailing bits are random and must be ignored.
        send_frame(0, 32'h1234, 32'hABCD, 16, 24, 1'b1);
        send_frame(0, 32'h00FF, 32'hFF00, 16, 24, 1'b1);
        check("oversize_drained", 64'(q16.size()), 64'd0);
        check("oversize_ferr", 64'(if16.frame_error), 64'd0);

        // Short left slot: error flagged, that frame dropped, next frame good.
        send_slot(0, 1'b0, 32'h1111, 16, 10, 1'b0, 32'h0, 32'h0);
        send_slot(0, 1'b1, 32'h2222, 16, 32, 1'b0, 32'h0, 32'h0);
        check("short_ferr_set", 64'(if16.frame_error), 64'd1);
        send_frame(0, 32'h3333, 32'h4444, 16, 32, 1'b1);
        check("short_recover", 64'(q16.size()), 64'd0);
        check("short_ferr_sticky", 64'(if16.frame_error), 64'd1);
        pulse_clear();
        check("ferr_cleared", 64'(if16.frame_error), 64'd0);

        // Clear asserted exactly in the set cycle: set wins.
        send_slot(0, 1'b0, 32'h1111, 16, 10, 1'b0, 32'h0, 32'h0);
        clr_on_le = 1'b1;
        send_slot(0, 1'b1, 32'h2222, 16, 32, 1'b0, 32'h0, 32'h0);
        clr_on_le = 1'b0;
        check("ferr_set_beats_clr", 64'(if16.frame_error), 64'd1);
        pulse_clear();
        check("ferr_cleared2", 64'(if16.frame_error), 64'd0);

        // Reset after 7 bits of the right word.
        send_frame(0, 32'h0F0F, 32'hF0F0, 16, 32, 1'b1);
        send_slot(0, 1'b0, 32'h1357, 16, 32, 1'b0, 32'h0, 32'h0);
        send_slot(0, 1'b1, 32'h9BDF, 16, 8, 1'b0, 32'h0, 32'h0);
        check("pre_rst_left", 64'(if16.left), 64'h0F0F);
        rst = 1'b1;
        #1;
        check("async_rst_left", 64'(if16.left), 64'd0);
        check("async_rst_right", 64'(if16.right), 64'd0);
        check("async_rst_valid", 64'(if16.valid), 64'd0);
        check("async_rst_ferr", 64'(if16.frame_error), 64'd0);
        line_reset(0);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        send_frame(0, 32'h2468, 32'h1357, 16, 32, 1'b0);
        send_frame(0, 32'h2468, 32'h9BDF, 16, 32, 1'b1);
        check("post_rst_pair", 64'(q16.size()), 64'd0);

        // Reset released with lrclk high mid-slot: the orphan right word is dropped.
        rst = 1'b1;
        lrclk_l[0] = 1'b1;
        line_reset(0);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        send_slot(0, 1'b1, 32'hAAAA, 16, 24, 1'b0, 32'h0, 32'h0);
        check("start_right_no_valid", 64'(if16.left), 64'd0);
        send_frame(0, 32'h6A6A, 32'h1F1F, 16, 32, 1'b1);
        check("start_right_pair", 64'(q16.size()), 64'd0);
        check("start_right_ferr", 64'(if16.frame_error), 64'd0);

        // Exact fit: 32-bit words in 32-bit slots; each LSB lands on the lrclk edge.
        send_slot(1, 1'b1, 32'h0, 32, 32, 1'b0, 32'h0, 32'h0);
        send_frame(1, 32'hDEADBEEF, 32'h01234567, 32, 32, 1'b1);
        send_frame(1, 32'hC0FFEE00, 32'h89ABCDEF, 32, 32, 1'b1);
        send_slot(1, 1'b0, 32'h0, 32, 32, 1'b0, 32'h0, 32'h0);
        check("exact_drained", 64'(q32.size()), 64'd0);
        check("exact_ferr", 64'(if32.frame_error), 64'd0);
        check("exact_hold_left", 64'(if32.left), 64'hC0FFEE00);
        check("exact_hold_right", 64'(if32.right), 64'h89ABCDEF);

        repeat (10) @(negedge clk);
        check("final_q16", 64'(q16.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
